mem_wb_stage: RTL and testbench

- Memory and write-back back-end for the 16-bit MIPS pipeline. It sits directly downstream of the EX stage.
- It registers EX results into an EX/MEM latch, performs `lw`/`sw` against a word-organised data memory, and registers the write-back value into a MEM/WB latch.
- The latched write-back controls drive the register file. EX/MEM fields are exported so a hazard/forwarding unit can use them.

---
 rtl/mem_wb_stage.sv | 115 +++++++++++
 tb/tb_mem_wb_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB back-end of the 16-bit MIPS pipeline: EX/MEM latch, word-organised
// data memory for lw/sw, MEM/WB latch driving the register file.
module mem_wb_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [15:0] ex_aluout,
  input  logic [15:0] ex_storedata,
  input  logic [1:0]  ex_wr,
  input  logic        ex_regwrite,
  input  logic        ex_memwrite,
  input  logic        ex_memtoreg,
  output logic        exmem_regwrite,
  output logic [1:0]  exmem_wr,
  output logic [15:0] exmem_aluout,
  output logic        wb_regwrite,
  output logic [1:0]  wb_wr,
  output logic [15:0] wb_wd,
  output logic        misalign_err,
  output logic [15:0] store_count
);

  logic        exmem_regwrite_reg;
  logic        exmem_memwrite_reg;
  logic        exmem_memtoreg_reg;
  logic [1:0]  exmem_wr_reg;
  logic [15:0] exmem_aluout_reg;
  logic [15:0] exmem_storedata_reg;

  logic        wb_regwrite_reg;
  logic [1:0]  wb_wr_reg;
  logic [15:0] wb_wd_reg;
  logic        misalign_err_reg;
  logic [15:0] store_count_reg;

  logic [15:0] mem [DEPTH];

  logic [AW-1:0] mem_index;
  logic          misalign;
  logic          store_en;
  logic          bad_access;
  logic [15:0]   rd_data;
  logic          wb_regwrite_next;
  logic [15:0]   wb_wd_next;

  // Byte address -> word index; bits above AW are ignored so addresses wrap.
  assign mem_index  = exmem_aluout_reg[AW:1];
  assign misalign   = exmem_aluout_reg[0];
  assign store_en   = exmem_memwrite_reg & ~misalign;
  assign bad_access = (exmem_memwrite_reg | exmem_memtoreg_reg) & misalign;
  assign rd_data    = mem[mem_index];

  assign wb_wd_next       = exmem_memtoreg_reg ? rd_data : exmem_aluout_reg;
  assign wb_regwrite_next = exmem_regwrite_reg & ~exmem_memwrite_reg &
                            ~(exmem_memtoreg_reg & misalign);

  // EX/MEM latch; bubbles lose all side-effect controls.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exmem_regwrite_reg  <= 1'b0;
      exmem_memwrite_reg  <= 1'b0;
      exmem_memtoreg_reg  <= 1'b0;
      exmem_wr_reg        <= 2'd0;
      exmem_aluout_reg    <= 16'd0;
      exmem_storedata_reg <= 16'd0;
    end else begin
      exmem_regwrite_reg  <= ex_valid & ex_regwrite;
      exmem_memwrite_reg  <= ex_valid & ex_memwrite;
      exmem_memtoreg_reg  <= ex_valid & ex_memtoreg;
      exmem_wr_reg        <= ex_wr;
      exmem_aluout_reg    <= ex_aluout;
      exmem_storedata_reg <= ex_storedata;
    end
  end

  // Memory contents survive reset; a store caught by reset is simply dropped.
  always_ff @(negedge clock) begin
    if (reset_n && store_en) begin
      mem[mem_index] <= exmem_storedata_reg;
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_regwrite_reg  <= 1'b0;
      wb_wr_reg        <= 2'd0;
      wb_wd_reg        <= 16'd0;
      misalign_err_reg <= 1'b0;
      store_count_reg  <= 16'd0;
    end else begin
      wb_regwrite_reg <= wb_regwrite_next;
      wb_wr_reg       <= exmem_wr_reg;
      wb_wd_reg       <= wb_wd_next;
      if (bad_access) begin
        misalign_err_reg <= 1'b1;
      end
      if (store_en && store_count_reg != 16'hFFFF) begin
        store_count_reg <= store_count_reg + 16'd1;
      end
    end
  end

  assign exmem_regwrite = exmem_regwrite_reg;
  assign exmem_wr       = exmem_wr_reg;
  assign exmem_aluout   = exmem_aluout_reg;
  assign wb_regwrite    = wb_regwrite_reg;
  assign wb_wr          = wb_wr_reg;
  assign wb_wd          = wb_wd_reg;
  assign misalign_err   = misalign_err_reg;
  assign store_count    = store_count_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed table, mid-flight reset sequence and
// random traffic checked against an in-order instruction-level model.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic [15:0] ex_aluout;
  logic [15:0] ex_storedata;
  logic [1:0]  ex_wr;
  logic        ex_regwrite;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic        exmem_regwrite;
  logic [1:0]  exmem_wr;
  logic [15:0] exmem_aluout;
  logic        wb_regwrite;
  logic [1:0]  wb_wr;
  logic [15:0] wb_wd;
  logic        misalign_err;
  logic [15:0] store_count;

  mem_wb_stage #(.DEPTH(256), .AW(8)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ex_valid       (ex_valid),
    .ex_aluout      (ex_aluout),
    .ex_storedata   (ex_storedata),
    .ex_wr          (ex_wr),
    .ex_regwrite    (ex_regwrite),
    .ex_memwrite    (ex_memwrite),
    .ex_memtoreg    (ex_memtoreg),
    .exmem_regwrite (exmem_regwrite),
    .exmem_wr       (exmem_wr),
    .exmem_aluout   (exmem_aluout),
    .wb_regwrite    (wb_regwrite),
    .wb_wr          (wb_wr),
    .wb_wd          (wb_wd),
    .misalign_err   (misalign_err),
    .store_count    (store_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [1:0]  wr;
    logic        rw;
    logic        mw;
    logic        mt;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        e_rw;
    logic [1:0]  e_wr;
    logic [15:0] e_wd;
    logic [15:0] e_cnt;
    logic        e_err;
    logic        e_xrw;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: instructions retire in program order, one per edge,
  // the edge after they are presented.
  instr_t      pending[$];
  logic [15:0] mem_m [256];
  logic        m_rw;
  logic [1:0]  m_wr;
  logic [15:0] m_wd;
  logic        m_err;
  logic [15:0] m_cnt;

  function automatic instr_t ins(logic v, logic [15:0] alu, logic [15:0] sd,
                                 logic [1:0] wr, logic rw, logic mw, logic mt);
    instr_t r;
    r.v = v; r.alu = alu; r.sd = sd; r.wr = wr; r.rw = rw; r.mw = mw; r.mt = mt;
    return r;
  endfunction

  function automatic vec_t vec(instr_t i, logic rw, logic [1:0] wr, logic [15:0] wd,
                               logic [15:0] cnt, logic err, logic xrw);
    vec_t r;
    r.in = i; r.e_rw = rw; r.e_wr = wr; r.e_wd = wd;
    r.e_cnt = cnt; r.e_err = err; r.e_xrw = xrw;
    return r;
  endfunction

  task automatic model_reset();
    pending.delete();
    m_rw = 1'b0; m_wr = 2'd0; m_wd = 16'd0; m_err = 1'b0; m_cnt = 16'd0;
  endtask

  task automatic model_edge(instr_t c);
    instr_t p;
    int     idx;
    logic   is_load, is_store, odd;
    if (pending.size() > 0) begin
      p        = pending.pop_front();
      is_load  = p.v & p.mt;
      is_store = p.v & p.mw;
      odd      = p.alu[0];
      idx      = (int'(p.alu) / 2) % 256;
      m_wd     = is_load ? mem_m[idx] : p.alu;
      m_wr     = p.wr;
      m_rw     = p.v & p.rw & ~is_store & ~(is_load & odd);
      if ((is_load || is_store) && odd) m_err = 1'b1;
      if (is_store && !odd) begin
        mem_m[idx] = p.sd;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end else begin
      m_rw = 1'b0; m_wr = 2'd0; m_wd = 16'd0;
    end
    pending.push_back(c);
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic        x_rw;
    logic [1:0]  x_wr;
    logic [15:0] x_alu;
    x_rw = 1'b0; x_wr = 2'd0; x_alu = 16'd0;
    if (pending.size() > 0) begin
      x_rw  = pending[0].v & pending[0].rw;
      x_wr  = pending[0].wr;
      x_alu = pending[0].alu;
    end
    chk("exmem_regwrite", 16'(exmem_regwrite), 16'(x_rw));
    chk("exmem_wr",       16'(exmem_wr),       16'(x_wr));
    chk("exmem_aluout",   exmem_aluout,        x_alu);
    chk("wb_regwrite",    16'(wb_regwrite),    16'(m_rw));
    chk("wb_wr",          16'(wb_wr),          16'(m_wr));
    chk("wb_wd",          wb_wd,               m_wd);
    chk("misalign_err",   16'(misalign_err),   16'(m_err));
    chk("store_count",    store_count,         m_cnt);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_exmem_regwrite"}, 16'(exmem_regwrite), 16'd0);
    chk({tag, "_exmem_wr"},       16'(exmem_wr),       16'd0);
    chk({tag, "_exmem_aluout"},   exmem_aluout,        16'd0);
    chk({tag, "_wb_regwrite"},    16'(wb_regwrite),    16'd0);
    chk({tag, "_wb_wr"},          16'(wb_wr),          16'd0);
    chk({tag, "_wb_wd"},          wb_wd,               16'd0);
    chk({tag, "_misalign_err"},   16'(misalign_err),   16'd0);
    chk({tag, "_store_count"},    store_count,         16'd0);
  endtask

  // One transaction: drive after posedge, DUT acts on negedge, check at next posedge.
  task automatic cycle(instr_t c);
    ex_valid = c.v; ex_aluout = c.alu; ex_storedata = c.sd; ex_wr = c.wr;
    ex_regwrite = c.rw; ex_memwrite = c.mw; ex_memtoreg = c.mt;
    @(negedge clock);
    if (reset_n) model_edge(c);
    else         model_reset();
    @(posedge clock);
    #1;
    check_all();
    $display("[%0t] rst_n=%b v=%b alu=%h sd=%h wr=%0d rw=%b mw=%b mt=%b -> wb rw=%b wr=%0d wd=%h err=%b cnt=%0d",
             $time, reset_n, c.v, c.alu, c.sd, c.wr, c.rw, c.mw, c.mt,
             wb_regwrite, wb_wr, wb_wd, misalign_err, store_count);
  endtask

  function automatic instr_t rnd_instr();
    instr_t r;
    int k;
    k     = $urandom_range(0, 3);
    r.v   = ($urandom_range(0, 7) != 0);
    r.alu = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
    r.sd  = 16'($urandom);
    r.wr  = 2'($urandom_range(0, 3));
    r.rw  = 1'b1; r.mw = 1'b0; r.mt = 1'b0;
    case (k)
      1: r.mt = 1'b1;
      2: begin r.mw = 1'b1; r.rw = 1'($urandom_range(0, 1)); end
      3: begin
        r.rw = 1'($urandom_range(0, 1));
        r.mw = 1'($urandom_range(0, 1));
        r.mt = 1'($urandom_range(0, 1));
      end
      default: ;
    endcase
    if ((r.mw || r.mt) && $urandom_range(0, 7) != 0) r.alu[0] = 1'b0;
    return r;
  endfunction

  task automatic do_reset(int cycles);
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) cycle(rnd_instr());
    check_zero("reset_hold");
    reset_n = 1'b1;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = vec(ins(1, 16'h000F, 16'h0000, 2'd1, 1, 0, 0), 0, 2'd0, 16'h0000, 16'd0, 0, 1);
    tbl[1]  = vec(ins(0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0), 1, 2'd1, 16'h000F, 16'd0, 0, 0);
    tbl[2]  = vec(ins(1, 16'h0010, 16'h1234, 2'd0, 1, 1, 0), 0, 2'd0, 16'h0000, 16'd0, 0, 1);
    tbl[3]  = vec(ins(1, 16'h0010, 16'h0000, 2'd2, 1, 0, 1), 0, 2'd0, 16'h0010, 16'd1, 0, 1);
    tbl[4]  = vec(ins(1, 16'h0200, 16'hBEEF, 2'd0, 0, 1, 0), 1, 2'd2, 16'h1234, 16'd1, 0, 0);
    tbl[5]  = vec(ins(1, 16'h0000, 16'h0000, 2'd3, 1, 0, 1), 0, 2'd0, 16'h0200, 16'd2, 0, 1);
    tbl[6]  = vec(ins(1, 16'h0011, 16'h5555, 2'd0, 0, 1, 0), 1, 2'd3, 16'hBEEF, 16'd2, 0, 0);
    tbl[7]  = vec(ins(1, 16'h0010, 16'h0000, 2'd1, 1, 0, 1), 0, 2'd0, 16'h0011, 16'd2, 1, 1);
    tbl[8]  = vec(ins(1, 16'h0013, 16'h0000, 2'd2, 1, 0, 1), 1, 2'd1, 16'h1234, 16'd2, 1, 1);
    tbl[9]  = vec(ins(0, 16'h0020, 16'h7777, 2'd1, 1, 1, 0), 0, 2'd2, 16'hA009, 16'd2, 1, 0);
    tbl[10] = vec(ins(1, 16'h0020, 16'h0000, 2'd1, 1, 0, 1), 0, 2'd1, 16'h0020, 16'd2, 1, 1);
    tbl[11] = vec(ins(0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0), 1, 2'd1, 16'hA010, 16'd2, 1, 0);

    reset_n = 1'b0;
    ex_valid = 0; ex_aluout = 0; ex_storedata = 0; ex_wr = 0;
    ex_regwrite = 0; ex_memwrite = 0; ex_memtoreg = 0;
    @(posedge clock);
    #1;
    do_reset(4);

    // Give every word a known value: word i holds A000+i.
    for (int i = 0; i < 256; i++)
      cycle(ins(1, 16'(i * 2), 16'(16'hA000 + i), 2'd0, 0, 1, 0));
    cycle(ins(0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0));
    chk("init_store_count", store_count, 16'd256);

    do_reset(3);

    foreach (tbl[i]) begin
      cycle(tbl[i].in);
      chk($sformatf("tbl%0d_wb_regwrite", i), 16'(wb_regwrite), 16'(tbl[i].e_rw));
      chk($sformatf("tbl%0d_wb_wr", i),       16'(wb_wr),       16'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_wb_wd", i),       wb_wd,            tbl[i].e_wd);
      chk($sformatf("tbl%0d_store_count", i), store_count,      tbl[i].e_cnt);
      chk($sformatf("tbl%0d_misalign", i),    16'(misalign_err), 16'(tbl[i].e_err));
      chk($sformatf("tbl%0d_exmem_rw", i),    16'(exmem_regwrite), 16'(tbl[i].e_xrw));
    end

    // Reset lands between the sw entering EX/MEM and its commit edge.
    cycle(ins(1, 16'h0040, 16'hDEAD, 2'd0, 0, 1, 0));
    reset_n = 1'b0;
    model_reset();
    #1;
    check_zero("midflight");
    cycle(ins(0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0));
    reset_n = 1'b1;
    cycle(ins(1, 16'h0040, 16'h0000, 2'd1, 1, 0, 1));
    cycle(ins(0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0));
    chk("midflight_lw_old_data", wb_wd, 16'hA020);
    chk("midflight_lw_regwrite", 16'(wb_regwrite), 16'd1);
    chk("midflight_store_count", store_count, 16'd0);

    for (int i = 0; i < 400; i++) cycle(rnd_instr());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
